// File: rtl/axis_slave_data_check_mem.sv
// axis_slave_data_check_mem: AXI4-Stream sink checking a repeating 1,3,7,3 lane pattern, TLAST
// placement and one injected TREADY stall. Macro AXIS_CHECK_TSTRB_EN adds a full-strobe check.
//
// state | meaning
// RECV  | tready high, accepting and checking beats
// STALL | tready low for STALL_CYCLES cycles after beat STALL_WORD_ID
// DONE  | frame complete, tready low until reset
module axis_slave_data_check_mem #(
  parameter int C_S_AXIS_TDATA_WIDTH  = 64,
  parameter int NUMBER_OF_INPUT_WORDS = 10,
  parameter int STALL_WORD_ID         = 5,
  parameter int STALL_CYCLES          = 8,
  localparam int CW = $clog2(NUMBER_OF_INPUT_WORDS + 1)
) (
  input  logic                                s00_axis_aclk,
  input  logic                                s00_axis_areset,
  input  logic                                s00_axis_tvalid,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
  input  logic [(C_S_AXIS_TDATA_WIDTH/8)-1:0] s00_axis_tstrb,
  input  logic                                s00_axis_tlast,
  output logic                                s00_axis_tready,
  output logic [CW-1:0]                       word_count,
  output logic [CW-1:0]                       err_count,
  output logic [CW-1:0]                       first_err_idx,
  output logic                                done,
  output logic                                pass
);

  localparam int LANES = C_S_AXIS_TDATA_WIDTH / 32;
  localparam int SW    = (STALL_CYCLES > 0) ? $clog2(STALL_CYCLES + 1) : 1;
  localparam logic [CW-1:0] NMAX = CW'(NUMBER_OF_INPUT_WORDS);

  if (C_S_AXIS_TDATA_WIDTH % 32 != 0) begin : g_bad_width
    $error("C_S_AXIS_TDATA_WIDTH must be a multiple of 32");
  end

  typedef enum logic [1:0] {RECV, STALL, DONE} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   stall_cnt_q, stall_cnt_d;
  logic            tready_q, tready_d;
  logic [CW-1:0]   word_count_q, word_count_d;
  logic [CW-1:0]   err_count_q, err_count_d;
  logic [CW-1:0]   first_err_idx_q, first_err_idx_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;

  logic [31:0]                     wc_ext;
  logic [31:0]                     lane_val;
  logic [C_S_AXIS_TDATA_WIDTH-1:0] exp_data;
  logic                            accept;
  logic                            is_last;
  logic                            is_stall_beat;
  logic                            data_err;
  logic                            last_err;
  logic                            strb_err;
  logic                            beat_err;

  assign wc_ext        = 32'(word_count_q);
  assign accept        = s00_axis_tvalid & tready_q;
  assign is_last       = (wc_ext == 32'(NUMBER_OF_INPUT_WORDS - 1));
  assign is_stall_beat = (STALL_CYCLES > 0) && (wc_ext == 32'(STALL_WORD_ID)) && !is_last;

  // Lane pattern repeats every four beats: 1, 3, 7, 3.
  always_comb begin
    lane_val = 32'd1;
    case (wc_ext[1:0])
      2'd0:    lane_val = 32'd1;
      2'd1:    lane_val = 32'd3;
      2'd2:    lane_val = 32'd7;
      default: lane_val = 32'd3;
    endcase
    exp_data = '0;
    for (int l = 0; l < LANES; l++) begin
      exp_data[l*32 +: 32] = lane_val;
    end
  end

  assign data_err = (s00_axis_tdata != exp_data);
  assign last_err = (s00_axis_tlast != is_last);

`ifdef AXIS_CHECK_TSTRB_EN
  assign strb_err = (s00_axis_tstrb != '1);
`else
  logic unused_tstrb;
  assign unused_tstrb = ^s00_axis_tstrb;
  assign strb_err     = 1'b0;
`endif

  assign beat_err = data_err | last_err | strb_err;

  always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
    if (s00_axis_areset) begin
      state_q         <= RECV;
      stall_cnt_q     <= '0;
      tready_q        <= 1'b0;
      word_count_q    <= '0;
      err_count_q     <= '0;
      first_err_idx_q <= '1;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      stall_cnt_q     <= stall_cnt_d;
      tready_q        <= tready_d;
      word_count_q    <= word_count_d;
      err_count_q     <= err_count_d;
      first_err_idx_q <= first_err_idx_d;
      done_q          <= done_d;
      pass_q          <= pass_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    stall_cnt_d     = stall_cnt_q;
    word_count_d    = word_count_q;
    err_count_d     = err_count_q;
    first_err_idx_d = first_err_idx_q;
    done_d          = done_q;
    pass_d          = pass_q;

    case (state_q)
      RECV: begin
        if (accept) begin
          if (word_count_q != NMAX) begin
            word_count_d = word_count_q + CW'(1);
          end
          if (beat_err) begin
            if (err_count_q != NMAX) begin
              err_count_d = err_count_q + CW'(1);
            end
            if (err_count_q == '0) begin
              first_err_idx_d = word_count_q;
            end
          end
          // Frame end is decided by beat count alone; an early tlast only counts as an error.
          if (is_last) begin
            state_d = DONE;
            done_d  = 1'b1;
            pass_d  = !beat_err && (err_count_q == '0);
          end else if (is_stall_beat) begin
            state_d     = STALL;
            stall_cnt_d = SW'(STALL_CYCLES);
          end
        end
      end
      STALL: begin
        stall_cnt_d = stall_cnt_q - SW'(1);
        if (stall_cnt_q == SW'(1)) begin
          state_d = RECV;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = RECV;
      end
    endcase

    tready_d = (state_d == RECV);
  end

  assign s00_axis_tready = tready_q;
  assign word_count      = word_count_q;
  assign err_count       = err_count_q;
  assign first_err_idx   = first_err_idx_q;
  assign done            = done_q;
  assign pass            = pass_q;

  // A waiting master must not change the beat it is offering.
  property p_hold_stable;
    @(posedge s00_axis_aclk) disable iff (s00_axis_areset)
      (s00_axis_tvalid && !s00_axis_tready) |=>
        ($stable(s00_axis_tdata) && $stable(s00_axis_tlast));
  endproperty

  a_hold_stable: assert property (p_hold_stable)
    else $warning("axis protocol: tdata/tlast changed while tvalid=1 and tready=0");

endmodule

// File: tb/tb_axis_slave_data_check_mem.sv
// Directed bench for axis_slave_data_check_mem: clean, corrupted, sparse, reset and strobe frames.
module tb_axis_slave_data_check_mem;

  localparam int DW = 64;
  localparam int BW = DW / 8;
  localparam int N  = 10;
  localparam int CW = $clog2(N + 1);
  localparam int BUDGET = 40;
  localparam logic [CW-1:0] NONE = '1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tvalid = 1'b0;
  logic [DW-1:0] tdata = '0;
  logic [BW-1:0] tstrb = '1;
  logic          tlast = 1'b0;
  logic          tready;
  logic [CW-1:0] word_count;
  logic [CW-1:0] err_count;
  logic [CW-1:0] first_err_idx;
  logic          done;
  logic          pass;

  int n_checks = 0;
  int n_errors = 0;
  int lo_run   = 0;
  int last_run = 0;

  logic [63:0] exp_tbl [N] = '{
    64'h00000001_00000001, 64'h00000003_00000003, 64'h00000007_00000007,
    64'h00000003_00000003, 64'h00000001_00000001, 64'h00000003_00000003,
    64'h00000007_00000007, 64'h00000003_00000003, 64'h00000001_00000001,
    64'h00000003_00000003
  };

  axis_slave_data_check_mem #(
    .C_S_AXIS_TDATA_WIDTH (DW),
    .NUMBER_OF_INPUT_WORDS(N),
    .STALL_WORD_ID        (5),
    .STALL_CYCLES         (8)
  ) dut (
    .s00_axis_aclk  (clk),
    .s00_axis_areset(rst),
    .s00_axis_tvalid(tvalid),
    .s00_axis_tdata (tdata),
    .s00_axis_tstrb (tstrb),
    .s00_axis_tlast (tlast),
    .s00_axis_tready(tready),
    .word_count     (word_count),
    .err_count      (err_count),
    .first_err_idx  (first_err_idx),
    .done           (done),
    .pass           (pass)
  );

  always #5 clk = ~clk;

  // Length of the most recent run of tready-low cycles.
  always @(negedge clk) begin
    if (tready) begin
      if (lo_run != 0) last_run <= lo_run;
      lo_run <= 0;
    end else begin
      lo_run <= lo_run + 1;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic apply_reset();
    tvalid = 1'b0;
    tlast  = 1'b0;
    tstrb  = '1;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send_beat(input logic [63:0] d, input logic l, input logic [BW-1:0] s);
    int waits;
    tvalid = 1'b1;
    tdata  = d;
    tlast  = l;
    tstrb  = s;
    waits  = 0;
    @(negedge clk);
    while (!tready && waits < BUDGET) begin
      waits++;
      @(negedge clk);
    end
    check_val("beat_accept", tready, 1'b1);
    @(posedge clk);
    #1;
    tvalid = 1'b0;
  endtask

  task automatic run_frame(input int bad_data_idx, input int early_last_idx, input bit drop_last,
                           input int bad_strb_idx, input bit sparse);
    logic [63:0]   d;
    logic          l;
    logic [BW-1:0] s;
    for (int i = 0; i < N; i++) begin
      d = (i == bad_data_idx) ? 64'h00000003_00000002 : exp_tbl[i];
      l = ((i == N - 1) && !drop_last) || (i == early_last_idx);
      s = (i == bad_strb_idx) ? 8'h7F : 8'hFF;
      send_beat(d, l, s);
      if (i == 6) check_val("stall_len", 64'(last_run), 64'd8);
      if (i == N - 2) check_val("done_early", done, 1'b0);
      if (sparse && i != N - 1) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic check_final(input logic [CW-1:0] e_err, input logic [CW-1:0] e_idx,
                             input logic e_pass);
    check_val("word_count", word_count, 64'(N));
    check_val("err_count", err_count, e_err);
    check_val("first_err_idx", first_err_idx, e_idx);
    check_val("done", done, 1'b1);
    check_val("pass", pass, e_pass);
    check_val("tready_done", tready, 1'b0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_val("rst_tready", tready, 1'b0);
    check_val("rst_word_count", word_count, 0);
    check_val("rst_err_count", err_count, 0);
    check_val("rst_first_err", first_err_idx, NONE);
    check_val("rst_done", done, 1'b0);
    check_val("rst_pass", pass, 1'b0);
    rst = 1'b0;
    #1;
    check_val("tready_before_edge", tready, 1'b0);
    @(posedge clk);
    #1;
    check_val("tready_rise", tready, 1'b1);

    // Clean frame, tvalid held high
    run_frame(-1, -1, 1'b0, -1, 1'b0);
    check_final(0, NONE, 1'b1);
    tvalid = 1'b1;
    tdata  = exp_tbl[0];
    tlast  = 1'b0;
    repeat (3) @(negedge clk);
    check_val("done_tready_hold", tready, 1'b0);
    @(posedge clk);
    #1;
    tvalid = 1'b0;
    check_val("done_ignore_count", word_count, 64'(N));

    // Data corruption on beat 3
    apply_reset();
    run_frame(3, -1, 1'b0, -1, 1'b0);
    check_final(1, 3, 1'b0);

    // Early tlast on beat 4, missing tlast on beat 9
    apply_reset();
    run_frame(-1, 4, 1'b1, -1, 1'b0);
    check_final(2, 4, 1'b0);

    // Sparse tvalid
    apply_reset();
    run_frame(-1, -1, 1'b0, -1, 1'b1);
    check_final(0, NONE, 1'b1);

    // Reset during the stall after beat 5, with an error already recorded
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      send_beat((i == 2) ? 64'h00000003_00000002 : exp_tbl[i], 1'b0, '1);
    end
    tvalid = 1'b1;
    tdata  = exp_tbl[6];
    repeat (3) @(negedge clk);
    check_val("pre_rst_word_count", word_count, 6);
    check_val("pre_rst_err_count", err_count, 1);
    check_val("pre_rst_tready", tready, 1'b0);
    rst = 1'b1;
    #1;
    check_val("async_rst_word_count", word_count, 0);
    check_val("async_rst_err_count", err_count, 0);
    check_val("async_rst_first_err", first_err_idx, NONE);
    check_val("async_rst_tready", tready, 1'b0);
    tvalid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    run_frame(-1, -1, 1'b0, -1, 1'b0);
    check_final(0, NONE, 1'b1);

    // Partial strobe on beat 7
    apply_reset();
    run_frame(-1, -1, 1'b0, 7, 1'b0);
`ifdef AXIS_CHECK_TSTRB_EN
    check_final(1, 7, 1'b0);
`else
    check_final(0, NONE, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
